// File: rtl/menu_pkg.sv
// Shared types and default timing for the menu button conditioner.
package menu_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } btn_state_e;

  // Default timings in clock cycles.
  localparam int unsigned DefDebounceCycles     = 650000;
  localparam int unsigned DefRepeatDelayCycles  = 32500000;
  localparam int unsigned DefRepeatPeriodCycles = 9750000;

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-flop synchronizer, debouncer and auto-repeat FSM.
// pulse_o is combinational from channel state; the parent registers it.
module button_channel
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DefRepeatPeriodCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic level_o
);

  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TimerMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                     REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  logic [1:0]        sync_q;
  logic [CntW-1:0]   cnt_q;
  logic              level_q;
  btn_state_e        state_q;
  logic [TimerW-1:0] timer_q;

  logic mismatch, toggle, rise, fall, rep_due;

  // Debounce decode and pulse generation; a fall wins over a coincident repeat.
  always_comb begin
    mismatch = sync_q[1] ^ level_q;
    toggle   = mismatch && (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));
    rise     = toggle && !level_q;
    fall     = toggle && level_q;
    rep_due  = 1'b0;
    unique case (state_q)
      StDelay:  rep_due = repeat_en_i && (timer_q == TimerW'(REPEAT_DELAY_CYCLES - 1));
      StRepeat: rep_due = repeat_en_i && (timer_q == TimerW'(REPEAT_PERIOD_CYCLES - 1));
      default:  rep_due = 1'b0;
    endcase
    pulse_o = rise || (rep_due && !fall);
  end

  // Synchronizer and debounced level; the counter only runs on consecutive mismatches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (!mismatch || toggle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (toggle) begin
        level_q <= ~level_q;
      end
    end
  end

  // Auto-repeat FSM; disabling repeat parks in StDelay with the timer cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StDelay;
            timer_q <= '0;
          end
        end
        StDelay: begin
          if (fall) begin
            state_q <= StIdle;
            timer_q <= '0;
          end else if (!repeat_en_i) begin
            timer_q <= '0;
          end else if (rep_due) begin
            state_q <= StRepeat;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StRepeat: begin
          if (fall) begin
            state_q <= StIdle;
            timer_q <= '0;
          end else if (!repeat_en_i) begin
            state_q <= StDelay;
            timer_q <= '0;
          end else if (rep_due) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/menu_button_conditioner.sv
// Up/down menu button conditioner: two debounced channels with auto-repeat,
// coincident pulses dropped, step pulses registered.
module menu_button_conditioner
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DefRepeatPeriodCycles
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_up_in,
  input  logic raw_down_in,
  input  logic repeat_en_in,
  output logic btn_up,
  output logic btn_down,
  output logic up_held,
  output logic down_held
);

  logic up_pulse, down_pulse;
  logic btn_up_q, btn_down_q;

  button_channel #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
  ) u_up (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .raw_i      (raw_up_in),
    .repeat_en_i(repeat_en_in),
    .pulse_o    (up_pulse),
    .level_o    (up_held)
  );

  button_channel #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
  ) u_down (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .raw_i      (raw_down_in),
    .repeat_en_i(repeat_en_in),
    .pulse_o    (down_pulse),
    .level_o    (down_held)
  );

  // Register step pulses; simultaneous up and down are ambiguous, so both are dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
    end else begin
      btn_up_q   <= up_pulse & ~down_pulse;
      btn_down_q <= down_pulse & ~up_pulse;
    end
  end

  assign btn_up   = btn_up_q;
  assign btn_down = btn_down_q;

endmodule

// File: doc/menu_button_conditioner.md
MENU_BUTTON_CONDITIONER -- requirements
Module: menu_button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 650000, meaning synchronized input must be stable this many consecutive cycles to change debounced level (legal >= 1).
REQ-002 SHALL have parameter REPEAT_DELAY_CYCLES, default 32500000, meaning cycles from press pulse to first auto-repeat pulse (legal >= 1).
REQ-003 SHALL have parameter REPEAT_PERIOD_CYCLES, default 9750000, meaning cycles between subsequent auto-repeat pulses (legal >= 1).
REQ-004 SHALL have port clk_in, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n_in, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port raw_up_in, input, 1, asynchronous bouncing up pushbutton, 1 = pressed.
REQ-007 SHALL have port raw_down_in, input, 1, asynchronous bouncing down pushbutton, 1 = pressed.
REQ-008 SHALL have port repeat_en_in, input, 1, 1 = auto-repeat enabled while held.
REQ-009 SHALL have port btn_up, output, 1, single-cycle step-up pulse for menu.
REQ-010 SHALL have port btn_down, output, 1, single-cycle step-down pulse for menu.
REQ-011 SHALL have port up_held, output, 1, debounced up level.
REQ-012 SHALL have port down_held, output, 1, debounced down level.

Function
REQ-013 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-014 SHALL per channel count consecutive cycles where synchronized value != debounced level; counter clears on any match; debounced level toggles on the edge the count would reach DEBOUNCE_CYCLES.
REQ-015 SHALL, for raw sampled 1 at edge 0 and held, assert the press pulse in the cycle after edge DEBOUNCE_CYCLES+1, for exactly one cycle.
REQ-016 SHALL produce no pulse on debounced 1->0 (release).
REQ-017 SHALL run a per-channel FSM: IDLE (level 0) -> DELAY on debounced rise (press pulse) -> REPEAT after REPEAT_DELAY_CYCLES (repeat pulse) -> repeat pulse every REPEAT_PERIOD_CYCLES; any state -> IDLE on debounced fall.
REQ-018 SHALL, with repeat_en_in = 0, hold the FSM in DELAY with timer cleared and emit no repeat pulses; repeat_en_in rising while held restarts the full REPEAT_DELAY_CYCLES.
REQ-019 SHALL size all counters as $clog2(parameter+1) bits; no counter shall wrap.
REQ-020 SHALL drop both channel pulses when they coincide in the same cycle; btn_up and btn_down are never both 1.
REQ-021 SHALL register btn_up/btn_down (no combinational path from inputs).
REQ-022 SHALL treat a button still pressed at reset release as a new press (pulse after DEBOUNCE_CYCLES+1 edges of stable 1).

Reset
REQ-023 SHALL, on rst_n_in = 0, immediately clear synchronizers, counters, debounced levels, FSMs to IDLE, and all four outputs to 0, regardless of clock.
REQ-024 SHALL, mid-debounce or mid-repeat reset, discard all partial progress; no pulse is emitted in the cycle after deassertion.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, DELAY, REPEAT) and default timing constants in shared package menu_pkg.
REQ-026 SHALL implement one channel (synchronizer, debouncer, FSM, timer) as sub-module button_channel, instantiated twice; the top adds coincidence suppression and output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3)
REQ-027 SHALL cover: raw_up_in high from edge 0 for 20 cycles, repeat_en_in=0 -> one btn_up pulse after edge 5, up_held 1 from edge 5, no pulse on release.
REQ-028 SHALL cover: raw_up_in toggles every 2 cycles for 12 cycles then stays 1 -> no pulse during bounce, exactly one pulse 5 edges after final rise.
REQ-029 SHALL cover: raw_down_in held 40 cycles, repeat_en_in=1 -> btn_down pulses after edges 5, 15, 18, 21, 24 ... until release.
REQ-030 SHALL cover: raw_up_in and raw_down_in rise on same edge -> no btn_up/btn_down pulse; both held levels 1.
REQ-031 SHALL cover: rst_n_in low asynchronously mid-repeat -> all outputs 0 before next edge; after release with raw still 1, single pulse 5 edges later.
REQ-032 SHALL cover: release bouncing 3 cycles then 0 -> up_held falls once, no btn_up pulse.
